// File: rtl/nco_clkgen_if.sv
// Configuration write channel for nco_clkgen: valid/ready handshake carrying a
// target channel, a new frequency word and a one-shot phase offset.
interface nco_clkgen_if #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned ACC_W = 16
) ();
  localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic             wr_valid;
  logic             wr_ready;
  logic [CH_W-1:0]  wr_ch;
  logic [ACC_W-1:0] wr_fcw;
  logic [ACC_W-1:0] wr_phase;

  modport master (
    output wr_valid,
    output wr_ch,
    output wr_fcw,
    output wr_phase,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_ch,
    input  wr_fcw,
    input  wr_phase,
    output wr_ready
  );
endinterface

// File: rtl/nco_clkgen.sv
// Multi-channel NCO clock generator with a stretched reset output. Frequency
// writes are shadowed and applied on the channel's next wrap so no pulse is cut.
module nco_clkgen #(
  parameter int unsigned N_CH      = 4,
  parameter int unsigned ACC_W     = 16,
  parameter int unsigned STARTUP_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  nco_clkgen_if.slave     wr,
  input  logic [N_CH-1:0] ch_en,
  output logic            rst_out,
  output logic [N_CH-1:0] ch_clk,
  output logic [N_CH-1:0] ch_tick,
  output logic [N_CH-1:0] pending
);

  localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  // Startup stretch: rst_out is the inverted MSB of a counter that stops once set.
  logic [STARTUP_W-1:0] start_cnt_q, start_cnt_d;

  assign rst_out = ~start_cnt_q[STARTUP_W-1];

  always_comb begin
    start_cnt_d = start_cnt_q;
    if (rst_out) begin
      start_cnt_d = start_cnt_q + STARTUP_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_cnt_q <= '0;
    end else begin
      start_cnt_q <= start_cnt_d;
    end
  end

  // Out-of-range channel numbers never match, so they see wr_ready low.
  logic wr_ready_c;
  logic wr_accept;

  always_comb begin
    wr_ready_c = 1'b0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (wr.wr_ch == CH_W'(i)) begin
        wr_ready_c = ~pending[i];
      end
    end
    wr_ready_c = wr_ready_c & ~rst_out;
  end

  assign wr.wr_ready = wr_ready_c;
  assign wr_accept   = wr.wr_valid & wr_ready_c;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] fcw_q, fcw_d;
    logic [ACC_W-1:0] sh_fcw_q, sh_fcw_d;
    logic [ACC_W-1:0] sh_ph_q, sh_ph_d;
    logic             pend_q, pend_d;
    logic             tick_q, tick_d;
    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] base;
    logic             run;
    logic             sel;
    logic             apply;

    always_comb begin
      run   = ch_en[g] & ~rst_out;
      sel   = wr_accept & (wr.wr_ch == CH_W'(g));
      sum   = {1'b0, acc_q} + {1'b0, fcw_q};
      base  = run ? sum[ACC_W-1:0] : acc_q;
      // A stopped or zero-rate channel never wraps, so its write lands immediately.
      apply = pend_q & ~rst_out & (~run | sum[ACC_W] | (fcw_q == '0));

      acc_d    = base;
      fcw_d    = fcw_q;
      sh_fcw_d = sh_fcw_q;
      sh_ph_d  = sh_ph_q;
      pend_d   = pend_q;
      tick_d   = run & sum[ACC_W];

      if (apply) begin
        fcw_d  = sh_fcw_q;
        acc_d  = base + sh_ph_q;
        pend_d = 1'b0;
      end
      if (sel) begin
        sh_fcw_d = wr.wr_fcw;
        sh_ph_d  = wr.wr_phase;
        pend_d   = 1'b1;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        acc_q    <= '0;
        fcw_q    <= '0;
        sh_fcw_q <= '0;
        sh_ph_q  <= '0;
        pend_q   <= 1'b0;
        tick_q   <= 1'b0;
      end else begin
        acc_q    <= acc_d;
        fcw_q    <= fcw_d;
        sh_fcw_q <= sh_fcw_d;
        sh_ph_q  <= sh_ph_d;
        pend_q   <= pend_d;
        tick_q   <= tick_d;
      end
    end

    assign ch_clk[g]  = acc_q[ACC_W-1];
    assign ch_tick[g] = tick_q;
    assign pending[g] = pend_q;
  end

endmodule

// File: tb/tb_nco_clkgen.sv
// Scoreboard bench for nco_clkgen: directed writes push hand-derived expectations,
// a monitor pops and compares them at each falling edge (or on demand).
module tb_nco_clkgen;

  typedef enum int {KRstOut, KReady, KClk, KTick, KPend} kind_e;
  typedef struct {
    string       name;
    kind_e       kind;
    logic [15:0] mask;
    logic [15:0] val;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] ch_en = 4'h0;
  logic       rst_out;
  logic [3:0] ch_clk;
  logic [3:0] ch_tick;
  logic [3:0] pending;

  exp_t        q[$];
  exp_t        mon_e;
  logic [15:0] mon_act;
  int          n_vec  = 0;
  int          n_miss = 0;
  event        sample_ev;

  logic c_tab[9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic t_tab[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic p_tab[9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  nco_clkgen_if #(.N_CH(4), .ACC_W(16)) bus ();

  nco_clkgen #(.N_CH(4), .ACC_W(16), .STARTUP_W(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .wr      (bus.slave),
    .ch_en   (ch_en),
    .rst_out (rst_out),
    .ch_clk  (ch_clk),
    .ch_tick (ch_tick),
    .pending (pending)
  );

  always #5 clk = ~clk;

  always @(negedge clk or sample_ev) begin
    while (q.size() > 0) begin
      mon_e = q.pop_front();
      case (mon_e.kind)
        KRstOut: mon_act = {15'b0, rst_out};
        KReady:  mon_act = {15'b0, bus.wr_ready};
        KClk:    mon_act = {12'b0, ch_clk};
        KTick:   mon_act = {12'b0, ch_tick};
        default: mon_act = {12'b0, pending};
      endcase
      n_vec++;
      if ((mon_act & mon_e.mask) !== (mon_e.val & mon_e.mask)) begin
        n_miss++;
        $display("FAIL %s @%0t: got %h want %h (mask %h)", mon_e.name, $time,
                 mon_act & mon_e.mask, mon_e.val & mon_e.mask, mon_e.mask);
      end
    end
  end

  task automatic expect_sig(input string name, input kind_e k, input logic [15:0] mask,
                            input logic [15:0] val);
    exp_t e;
    e.name = name;
    e.kind = k;
    e.mask = mask;
    e.val  = val;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [1:0] ch, input logic [15:0] fcw, input logic [15:0] ph);
    bus.wr_valid = 1'b1;
    bus.wr_ch    = ch;
    bus.wr_fcw   = fcw;
    bus.wr_phase = ph;
    expect_sig("wr_ready_at_write", KReady, 16'h1, 16'h1);
    step();
    bus.wr_valid = 1'b0;
  endtask

  task automatic expect_reset_state(input string tag);
    expect_sig({tag, "_rst_out"}, KRstOut, 16'h1, 16'h1);
    expect_sig({tag, "_wr_ready"}, KReady, 16'h1, 16'h0);
    expect_sig({tag, "_ch_clk"}, KClk, 16'hF, 16'h0);
    expect_sig({tag, "_ch_tick"}, KTick, 16'hF, 16'h0);
    expect_sig({tag, "_pending"}, KPend, 16'hF, 16'h0);
  endtask

  task automatic startup_check();
    for (int i = 0; i < 8; i++) begin
      expect_sig("startup_rst_out_high", KRstOut, 16'h1, 16'h1);
      expect_sig("startup_wr_ready_low", KReady, 16'h1, 16'h0);
      step();
    end
    expect_sig("startup_rst_out_low", KRstOut, 16'h1, 16'h0);
    expect_sig("startup_wr_ready_high", KReady, 16'h1, 16'h1);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic c2;
    bus.wr_valid = 1'b0;
    bus.wr_ch    = 2'd0;
    bus.wr_fcw   = 16'h0;
    bus.wr_phase = 16'h0;
    #1;
    expect_reset_state("reset");
    step();
    rst = 1'b0;
    startup_check();

    // ch0 from fcw=0: applied next cycle, period 4, 2 high / 2 low.
    ch_en = 4'hF;
    do_write(2'd0, 16'h4000, 16'h0);
    expect_sig("ch0_pending_set", KPend, 16'hF, 16'h1);
    step();
    expect_sig("ch0_pending_clr", KPend, 16'h1, 16'h0);
    expect_sig("ch0_clk_apply", KClk, 16'h1, 16'h0);
    expect_sig("ch0_tick_apply", KTick, 16'h1, 16'h0);
    for (int m = 1; m <= 8; m++) begin
      step();
      expect_sig("ch0_clk_run", KClk, 16'h1, {15'b0, (m % 4) >= 2});
      expect_sig("ch0_tick_run", KTick, 16'h1, {15'b0, (m % 4) == 0});
    end

    // ch1 at 0x2000, then 0x8000 written mid-period waits for the wrap.
    do_write(2'd1, 16'h2000, 16'h0);
    expect_sig("ch1_pending_set", KPend, 16'h2, 16'h2);
    step();
    expect_sig("ch1_pending_clr", KPend, 16'h2, 16'h0);
    expect_sig("ch1_clk_0", KClk, 16'h2, 16'h0);
    step();
    expect_sig("ch1_clk_2000", KClk, 16'h2, 16'h0);
    step();
    expect_sig("ch1_clk_4000", KClk, 16'h2, 16'h0);
    do_write(2'd1, 16'h8000, 16'h0);
    expect_sig("ch1_pending_mid", KPend, 16'h2, 16'h2);
    expect_sig("ch1_wr_ready_blocked", KReady, 16'h1, 16'h0);
    expect_sig("ch1_clk_6000", KClk, 16'h2, 16'h0);
    for (int j = 0; j < 9; j++) begin
      step();
      expect_sig("ch1_clk_switch", KClk, 16'h2, {14'b0, c_tab[j], 1'b0});
      expect_sig("ch1_tick_switch", KTick, 16'h2, {14'b0, t_tab[j], 1'b0});
      expect_sig("ch1_pend_switch", KPend, 16'h2, {14'b0, p_tab[j], 1'b0});
    end

    // ch2/ch3 loaded while stopped so they start aligned; then ch3 gets a half-turn.
    ch_en = 4'b0011;
    do_write(2'd2, 16'h1000, 16'h0);
    do_write(2'd3, 16'h1000, 16'h0);
    step();
    expect_sig("ch23_pending_clr", KPend, 16'hC, 16'h0);
    expect_sig("ch23_clk_frozen", KClk, 16'hC, 16'h0);
    ch_en = 4'hF;
    step();
    do_write(2'd3, 16'h1000, 16'h8000);
    for (int k = 37; k <= 50; k++) begin
      expect_sig("ch3_pending_wait", KPend, 16'h8, 16'h8);
      expect_sig("ch23_clk_aligned", KClk, 16'hC, ((k - 35) >= 8) ? 16'hC : 16'h0);
      expect_sig("ch23_tick_none", KTick, 16'hC, 16'h0);
      step();
    end
    expect_sig("ch3_pending_applied", KPend, 16'h8, 16'h0);
    expect_sig("ch23_tick_wrap", KTick, 16'hC, 16'hC);
    expect_sig("ch23_clk_apply", KClk, 16'hC, 16'h8);
    for (int m = 1; m <= 20; m++) begin
      step();
      c2 = (m % 16) >= 8;
      expect_sig("ch23_clk_inverted", KClk, 16'hC, {12'b0, ~c2, c2, 2'b00});
      expect_sig("ch23_tick_offset", KTick, 16'hC,
                 {12'b0, (m % 16) == 8, (m % 16) == 0, 2'b00});
    end

    // ch0 frozen while disabled; a write lands without waiting for a wrap.
    step();
    expect_sig("ch0_clk_pre_freeze", KClk, 16'h1, 16'h1);
    expect_sig("ch0_tick_pre_freeze", KTick, 16'h1, 16'h0);
    ch_en = 4'b1110;
    for (int i = 0; i < 5; i++) begin
      step();
      expect_sig("ch0_clk_frozen", KClk, 16'h1, 16'h1);
      expect_sig("ch0_tick_frozen", KTick, 16'h1, 16'h0);
    end
    do_write(2'd0, 16'h4000, 16'h4000);
    expect_sig("ch0_pending_disabled", KPend, 16'h1, 16'h1);
    expect_sig("ch0_clk_held", KClk, 16'h1, 16'h1);
    step();
    expect_sig("ch0_pending_applied", KPend, 16'h1, 16'h0);
    expect_sig("ch0_clk_c000", KClk, 16'h1, 16'h1);
    expect_sig("ch0_tick_disabled", KTick, 16'h1, 16'h0);
    ch_en = 4'hF;
    step();
    expect_sig("ch0_clk_resume", KClk, 16'h1, 16'h0);
    expect_sig("ch0_tick_resume", KTick, 16'h1, 16'h1);
    step();
    expect_sig("ch0_clk_4000", KClk, 16'h1, 16'h0);
    expect_sig("ch0_tick_4000", KTick, 16'h1, 16'h0);
    step();
    expect_sig("ch0_clk_8000", KClk, 16'h1, 16'h1);

    // Asynchronous reset with ch1 pending, checked before the next rising edge.
    do_write(2'd1, 16'h8000, 16'h0);
    expect_sig("ch1_pending_before_rst", KPend, 16'hF, 16'h2);
    #6;
    rst = 1'b1;
    #1;
    expect_reset_state("async_rst");
    ->sample_ev;
    step();
    expect_reset_state("rst_held");
    rst = 1'b0;
    startup_check();
    expect_sig("post_rst_pending", KPend, 16'hF, 16'h0);
    expect_sig("post_rst_clk", KClk, 16'hF, 16'h0);
    step();
    expect_sig("post_rst_tick", KTick, 16'hF, 16'h0);
    expect_sig("post_rst_clk_idle", KClk, 16'hF, 16'h0);

    step();
    if (q.size() != 0) begin
      n_miss++;
      $display("FAIL scoreboard_drain: got %0d entries left want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
